dram_scheduler: RTL and testbench
=================================

Name: dram_scheduler

Overview:
- In-order DDR4 command scheduler in front of the DRAM channel model.
- Accepts one memory request at a time via valid/ready.
- Classifies each request as HIT, MISS or EMPTY against a 16-bank open-row table (4 bank groups × 4 banks).
- Issues timing-legal PRE/ACT/RD/WR commands, one per cycle at most, and pulses completion when the data burst ends.
- All timing is in DRAM command-clock cycles of clk.

Parameters:
- T_RAS, 52, min ACT→PRE same bank
- T_RCD, 24, min ACT→RD/WR same bank
- T_RP, 24, min PRE→ACT same bank
- T_CL, 24, RD→data start
- T_CWD, 20, WR→data start
- T_BURST, 4, data burst length
- T_WR, 20, write recovery after burst end before PRE
- T_RRD_L / T_RRD_S, 6 / 4, ACT→ACT same / different bank group
- T_CCD_L / T_CCD_S, 8 / 4, CAS→CAS same / different bank group
- DONE_DEPTH, 8, outstanding-burst tracker entries

Ports:
- clk  in  1  command clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  scheduler can accept
- req_rd_wr  in  1  0 read, 1 write
- req_bank_group  in  2  target bank group
- req_bank  in  2  target bank
- req_row  in  15  target row
- req_column  in  11  target column
- cmd_valid  out  1  one-cycle command strobe
- cmd_op  out  3  0 NOP, 1 ACT, 2 PRE, 3 RD, 4 WR
- cmd_bank_group, cmd_bank  out  2,2  command target
- cmd_row  out  15  row (ACT only, else 0)
- cmd_column  out  11  column (RD/WR only, else 0)
- cmd_policy  out  2  classification of current request: 0 NULL, 1 HIT, 2 MISS, 3 EMPTY
- done  out  1  one-cycle pulse at burst end
- done_rd_wr  out  1  type of completed burst

Behaviour:
- Reset (async on rst_n low): FSM → IDLE, all banks closed, all elapsed counters saturated at 255, tracker empty. All outputs 0 except req_ready = 1.
- Reset mid-operation aborts the in-flight request and pending dones silently.
- Per-bank state:
  - open flag
  - open row
  - since_act: 8-bit saturating
  - since_wr: 8-bit saturating, counts from WR issue
  - since_pre: 8-bit saturating
- Global state:
  - since_act, last ACT BG
  - since_cas, last CAS BG, last CAS type
- Every counter increments each cycle, saturates at 255, and clears to 0 in the cycle its command issues.
- FSM:
  - IDLE: req_ready = 1. On req_valid, latch request → CLASSIFY.
  - CLASSIFY (1 cycle): bank closed → EMPTY, go ACT_WAIT. Open and row equal → HIT, go CAS_WAIT. Open and row differs → MISS, go PRE_WAIT. Drive cmd_policy from here until return to IDLE.
  - PRE_WAIT: issue PRE when since_act ≥ T_RAS and since_wr ≥ T_CWD+T_BURST+T_WR. Mark bank closed → ACT_WAIT.
  - ACT_WAIT: issue ACT when bank since_pre ≥ T_RP and global since_act ≥ (same BG ? T_RRD_L : T_RRD_S). Set open/row → CAS_WAIT.
  - CAS_WAIT: issue RD/WR when bank since_act ≥ T_RCD, since_cas ≥ (same BG ? T_CCD_L : T_CCD_S), tracker not full, and (type equals last CAS type or tracker empty). The last condition is the read/write turnaround rule. Push tracker → IDLE.
- Earliest command is 2 cycles after the accept edge. A HIT RD can therefore issue 2 cycles after accept if constraints are met.
- Tracker FIFO entry = {remaining countdown, rd_wr}:
  - Loaded with T_CL+T_BURST for reads, T_CWD+T_BURST for writes.
  - All entries decrement each cycle.
  - When the head reaches 0: done = 1, done_rd_wr = entry type, pop.
  - Turnaround plus FIFO order guarantees at most one done per cycle.
  - A push and a pop in the same cycle are both honoured.
- Rows stay open after CAS (open-page policy). There is no refresh.

Test Plan:
- Read, BG0/B0/row 5, from reset; accept at cycle 0 → EMPTY; ACT at 2; RD at 26; done (rd) at 54.
- Second read, same bank/row 5, accepted right after the first RD → HIT; RD no earlier than first RD+8 (T_CCD_L); done 28 after it.
- Read, BG0/B0/row 9 after ACT at cycle 2 → MISS; PRE at ≥54; ACT at PRE+24; RD at ACT+24.
- Back-to-back EMPTY reads, BG0/B0 then BG1/B0 → second ACT ≥ first+4. Repeat with BG0/B1 → ≥ first+6.
- Write BG2/B3 row 1, then read row 2 same bank → WR, then PRE ≥ WR+44 and ≥ ACT+52. The read-after-write CAS waits for the tracker to drain (no overlap).
- Assert rst_n low while in PRE_WAIT → outputs 0 immediately, req_ready = 1. Next request to the same bank classifies EMPTY; no stale done pulse appears.

Source files
------------

// File: rtl/dram_scheduler.sv
// In-order DDR4 command scheduler with a 16-bank open-row table.
// Ports:
//   clk, rst_n                      command clock, async active-low reset
//   req_valid/req_ready             one-at-a-time request handshake
//   req_rd_wr, req_bank_group,
//   req_bank, req_row, req_column   request payload (latched on accept)
//   cmd_valid, cmd_op               command strobe and opcode (NOP/ACT/PRE/RD/WR)
//   cmd_bank_group, cmd_bank,
//   cmd_row, cmd_column             command target
//   cmd_policy                      classification of the request in flight
//   done, done_rd_wr                pulse at data-burst end and its type
module dram_scheduler #(
  parameter int unsigned T_RAS      = 52,
  parameter int unsigned T_RCD      = 24,
  parameter int unsigned T_RP       = 24,
  parameter int unsigned T_CL       = 24,
  parameter int unsigned T_CWD      = 20,
  parameter int unsigned T_BURST    = 4,
  parameter int unsigned T_WR       = 20,
  parameter int unsigned T_RRD_L    = 6,
  parameter int unsigned T_RRD_S    = 4,
  parameter int unsigned T_CCD_L    = 8,
  parameter int unsigned T_CCD_S    = 4,
  parameter int unsigned DONE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd_wr,
  input  logic [1:0]  req_bank_group,
  input  logic [1:0]  req_bank,
  input  logic [14:0] req_row,
  input  logic [10:0] req_column,
  output logic        cmd_valid,
  output logic [2:0]  cmd_op,
  output logic [1:0]  cmd_bank_group,
  output logic [1:0]  cmd_bank,
  output logic [14:0] cmd_row,
  output logic [10:0] cmd_column,
  output logic [1:0]  cmd_policy,
  output logic        done,
  output logic        done_rd_wr
);

  localparam int unsigned NBANK  = 16;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned TRK_W  = 6;
  localparam int unsigned TRK_NW = $clog2(DONE_DEPTH + 1);
  localparam int unsigned TRK_IW = $clog2(DONE_DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLASSIFY = 3'd1;
  localparam logic [2:0] S_PRE_WAIT = 3'd2;
  localparam logic [2:0] S_ACT_WAIT = 3'd3;
  localparam logic [2:0] S_CAS_WAIT = 3'd4;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ACT = 3'd1;
  localparam logic [2:0] OP_PRE = 3'd2;
  localparam logic [2:0] OP_RD  = 3'd3;
  localparam logic [2:0] OP_WR  = 3'd4;

  localparam logic [1:0] POL_NULL  = 2'd0;
  localparam logic [1:0] POL_HIT   = 2'd1;
  localparam logic [1:0] POL_MISS  = 2'd2;
  localparam logic [1:0] POL_EMPTY = 2'd3;

  localparam logic [TRK_W-1:0] LOAD_RD = TRK_W'(T_CL + T_BURST);
  localparam logic [TRK_W-1:0] LOAD_WR = TRK_W'(T_CWD + T_BURST);

  // Counters hold cycles since the command edge; the command about to issue
  // at the next edge sees one more elapsed cycle than the stored value.
  function automatic logic f_ge(input logic [CNT_W-1:0] cnt, input int unsigned t);
    return (32'(cnt) + 32'd1) >= t;
  endfunction

  function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  endfunction

  logic [2:0]       r_state, w_state_nxt;
  logic             w_accept, w_issue_pre, w_issue_act, w_issue_cas;

  logic             r_rw;
  logic [1:0]       r_bg, r_bk;
  logic [14:0]      r_row;
  logic [10:0]      r_col;
  logic [3:0]       w_idx;

  logic             r_open     [NBANK];
  logic [14:0]      r_open_row [NBANK];
  logic [CNT_W-1:0] r_bk_since_act [NBANK];
  logic [CNT_W-1:0] r_bk_since_wr  [NBANK];
  logic [CNT_W-1:0] r_bk_since_pre [NBANK];

  logic [CNT_W-1:0] r_g_since_act, r_g_since_cas;
  logic [1:0]       r_g_act_bg, r_g_cas_bg;
  logic             r_g_cas_rw;

  logic [TRK_W-1:0] r_trk_cnt [DONE_DEPTH];
  logic             r_trk_rw  [DONE_DEPTH];
  logic [TRK_NW-1:0] r_trk_n;
  logic             w_pop, w_trk_full, w_trk_empty;
  logic [TRK_IW-1:0] w_push_idx;

  logic             w_hit, w_pre_ok, w_act_ok, w_cas_ok;

  logic             r_req_ready, r_cmd_valid, r_done, r_done_rw;
  logic [2:0]       r_cmd_op;
  logic [1:0]       r_cmd_bg, r_cmd_bk, r_policy;
  logic [14:0]      r_cmd_row;
  logic [10:0]      r_cmd_col;

  assign w_idx       = {r_bg, r_bk};
  assign w_hit       = r_open[w_idx] && (r_open_row[w_idx] == r_row);
  assign w_trk_full  = (r_trk_n == TRK_NW'(DONE_DEPTH));
  assign w_trk_empty = (r_trk_n == '0);
  assign w_pop       = !w_trk_empty && (r_trk_cnt[0] == TRK_W'(1));
  assign w_push_idx  = TRK_IW'(r_trk_n - TRK_NW'(w_pop));

  assign w_pre_ok = f_ge(r_bk_since_act[w_idx], T_RAS) &&
                    f_ge(r_bk_since_wr[w_idx], T_CWD + T_BURST + T_WR);
  assign w_act_ok = f_ge(r_bk_since_pre[w_idx], T_RP) &&
                    f_ge(r_g_since_act, (r_bg == r_g_act_bg) ? T_RRD_L : T_RRD_S);
  // Read/write turnaround: switching CAS type only with an empty tracker.
  assign w_cas_ok = f_ge(r_bk_since_act[w_idx], T_RCD) &&
                    f_ge(r_g_since_cas, (r_bg == r_g_cas_bg) ? T_CCD_L : T_CCD_S) &&
                    !w_trk_full && ((r_rw == r_g_cas_rw) || w_trk_empty);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and command-issue decisions
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue_pre = 1'b0;
    w_issue_act = 1'b0;
    w_issue_cas = 1'b0;
    case (r_state)
      S_IDLE: if (req_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        if (!r_open[w_idx]) w_state_nxt = S_ACT_WAIT;
        else if (w_hit)     w_state_nxt = S_CAS_WAIT;
        else                w_state_nxt = S_PRE_WAIT;
      end
      S_PRE_WAIT: if (w_pre_ok) begin
        w_issue_pre = 1'b1;
        w_state_nxt = S_ACT_WAIT;
      end
      S_ACT_WAIT: if (w_act_ok) begin
        w_issue_act = 1'b1;
        w_state_nxt = S_CAS_WAIT;
      end
      S_CAS_WAIT: if (w_cas_ok) begin
        w_issue_cas = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw  <= 1'b0;
      r_bg  <= '0;
      r_bk  <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      r_rw  <= req_rd_wr;
      r_bg  <= req_bank_group;
      r_bk  <= req_bank;
      r_row <= req_row;
      r_col <= req_column;
    end
  end

  // Open-row table and per-bank elapsed counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBANK; i++) begin
        r_open[i]         <= 1'b0;
        r_open_row[i]     <= '0;
        r_bk_since_act[i] <= '1;
        r_bk_since_wr[i]  <= '1;
        r_bk_since_pre[i] <= '1;
      end
    end else begin
      for (int i = 0; i < NBANK; i++) begin
        r_bk_since_act[i] <= (w_issue_act && w_idx == 4'(i)) ? '0 : f_inc(r_bk_since_act[i]);
        r_bk_since_pre[i] <= (w_issue_pre && w_idx == 4'(i)) ? '0 : f_inc(r_bk_since_pre[i]);
        r_bk_since_wr[i]  <= (w_issue_cas && r_rw && w_idx == 4'(i)) ? '0 : f_inc(r_bk_since_wr[i]);
      end
      if (w_issue_pre) r_open[w_idx] <= 1'b0;
      if (w_issue_act) begin
        r_open[w_idx]     <= 1'b1;
        r_open_row[w_idx] <= r_row;
      end
    end
  end

  // Channel-wide ACT and CAS history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g_since_act <= '1;
      r_g_since_cas <= '1;
      r_g_act_bg    <= '0;
      r_g_cas_bg    <= '0;
      r_g_cas_rw    <= 1'b0;
    end else begin
      r_g_since_act <= w_issue_act ? '0 : f_inc(r_g_since_act);
      r_g_since_cas <= w_issue_cas ? '0 : f_inc(r_g_since_cas);
      if (w_issue_act) r_g_act_bg <= r_bg;
      if (w_issue_cas) begin
        r_g_cas_bg <= r_bg;
        r_g_cas_rw <= r_rw;
      end
    end
  end

  // Burst tracker: shift FIFO, every entry counts down, head pops at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trk_n <= '0;
      for (int i = 0; i < DONE_DEPTH; i++) begin
        r_trk_cnt[i] <= '0;
        r_trk_rw[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DONE_DEPTH - 1; i++) begin
        r_trk_cnt[i] <= w_pop ? r_trk_cnt[i+1] - TRK_W'(1) : r_trk_cnt[i] - TRK_W'(1);
        r_trk_rw[i]  <= w_pop ? r_trk_rw[i+1] : r_trk_rw[i];
      end
      r_trk_cnt[DONE_DEPTH-1] <= r_trk_cnt[DONE_DEPTH-1] - TRK_W'(1);
      if (w_issue_cas) begin
        r_trk_cnt[w_push_idx] <= r_rw ? LOAD_WR : LOAD_RD;
        r_trk_rw[w_push_idx]  <= r_rw;
      end
      r_trk_n <= r_trk_n + TRK_NW'(w_issue_cas) - TRK_NW'(w_pop);
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b1;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= OP_NOP;
      r_cmd_bg    <= '0;
      r_cmd_bk    <= '0;
      r_cmd_row   <= '0;
      r_cmd_col   <= '0;
      r_policy    <= POL_NULL;
      r_done      <= 1'b0;
      r_done_rw   <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_cmd_valid <= w_issue_pre || w_issue_act || w_issue_cas;
      r_cmd_op    <= OP_NOP;
      r_cmd_bg    <= '0;
      r_cmd_bk    <= '0;
      r_cmd_row   <= '0;
      r_cmd_col   <= '0;
      if (w_issue_pre || w_issue_act || w_issue_cas) begin
        r_cmd_bg <= r_bg;
        r_cmd_bk <= r_bk;
      end
      if (w_issue_pre) r_cmd_op <= OP_PRE;
      if (w_issue_act) begin
        r_cmd_op  <= OP_ACT;
        r_cmd_row <= r_row;
      end
      if (w_issue_cas) begin
        r_cmd_op  <= r_rw ? OP_WR : OP_RD;
        r_cmd_col <= r_col;
      end
      if (r_state == S_CLASSIFY)
        r_policy <= !r_open[w_idx] ? POL_EMPTY : (w_hit ? POL_HIT : POL_MISS);
      else if (r_state == S_IDLE)
        r_policy <= POL_NULL;
      r_done    <= w_pop;
      r_done_rw <= w_pop ? r_trk_rw[0] : 1'b0;
    end
  end

  assign req_ready      = r_req_ready;
  assign cmd_valid      = r_cmd_valid;
  assign cmd_op         = r_cmd_op;
  assign cmd_bank_group = r_cmd_bg;
  assign cmd_bank       = r_cmd_bk;
  assign cmd_row        = r_cmd_row;
  assign cmd_column     = r_cmd_col;
  assign cmd_policy     = r_policy;
  assign done           = r_done;
  assign done_rd_wr     = r_done_rw;

endmodule

// File: tb/tb_dram_scheduler.sv
// Bench for dram_scheduler: per-cycle comparison of every output against a
// timestamp-based model of the timing rules, directed test-plan scenarios,
// then randomized request streams.
module tb_dram_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_rd_wr;
  logic [1:0]  req_bank_group, req_bank;
  logic [14:0] req_row;
  logic [10:0] req_column;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_bank_group, cmd_bank, cmd_policy;
  logic [14:0] cmd_row;
  logic [10:0] cmd_column;
  logic        done, done_rd_wr;

  always #5 clk = ~clk;

  dram_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd_wr(req_rd_wr),
    .req_bank_group(req_bank_group), .req_bank(req_bank),
    .req_row(req_row), .req_column(req_column),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_bank_group(cmd_bank_group), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_column(cmd_column), .cmd_policy(cmd_policy),
    .done(done), .done_rd_wr(done_rd_wr)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: times (edge index) of the last commands, plus pending done edges.
  typedef struct { int d; logic rw; } done_t;
  done_t pend[$];
  int    m_act[16], m_pre[16], m_wr[16], m_row[16];
  bit    m_open[16];
  int    m_gact, m_gact_bg, m_gcas, m_gcas_bg;
  logic  m_gcas_rw;

  // Observations from the DUT outputs.
  int    obs_t[8];
  logic [1:0] obs_pol;
  int    obs_done_q[$];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_act[i] = -1000; m_pre[i] = -1000; m_wr[i] = -1000;
      m_row[i] = 0; m_open[i] = 0;
    end
    m_gact = -1000; m_gcas = -1000; m_gact_bg = 0; m_gcas_bg = 0;
    m_gcas_rw = 1'b0;
    pend.delete();
  endtask

  function automatic int n_pend_from(int t);
    int n = 0;
    foreach (pend[i]) if (pend[i].d >= t) n++;
    return n;
  endfunction

  function automatic logic [33:0] mk_cmd(logic [2:0] op, logic [1:0] bg, logic [1:0] b,
                                         logic [14:0] row, logic [10:0] col);
    return {1'b1, op, bg, b, row, col};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk_int(string tag, int observed, int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic chk_ge(string tag, int observed, int bound);
    checks++;
    assert (observed >= bound) else begin
      failures++;
      $error("FAIL %s observed=%0d expected>=%0d", tag, observed, bound);
    end
  endtask

  task automatic check_cycle(input logic [33:0] exp_cmd, input logic exp_rdy,
                             input logic [1:0] exp_pol);
    logic [1:0]  exp_done;
    logic [33:0] got_cmd;
    exp_done = 2'b00;
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].d == cyc) begin
        exp_done = {1'b1, pend[i].rw};
        pend.delete(i);
        break;
      end
    end
    got_cmd = {cmd_valid, cmd_op, cmd_bank_group, cmd_bank, cmd_row, cmd_column};
    if (cmd_valid) begin
      obs_t[cmd_op] = cyc;
      obs_pol = cmd_policy;
    end
    if (done) obs_done_q.push_back(cyc);
    checks++;
    assert (got_cmd === exp_cmd) else begin
      failures++;
      $error("FAIL cmd cyc=%0d observed=%h expected=%h", cyc, got_cmd, exp_cmd);
    end
    checks++;
    assert ({done, done_rd_wr} === exp_done) else begin
      failures++;
      $error("FAIL done cyc=%0d observed=%b expected=%b", cyc, {done, done_rd_wr}, exp_done);
    end
    checks++;
    assert (req_ready === exp_rdy) else begin
      failures++;
      $error("FAIL req_ready cyc=%0d observed=%b expected=%b", cyc, req_ready, exp_rdy);
    end
    checks++;
    assert (cmd_policy === exp_pol) else begin
      failures++;
      $error("FAIL policy cyc=%0d observed=%0d expected=%0d", cyc, cmd_policy, exp_pol);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      tick();
      check_cycle('0, 1'b1, 2'd0);
    end
  endtask

  // Present one request, predict its command schedule, check every cycle up
  // to its CAS (or up to stop cycles after accept).
  task automatic run_req(input logic rw, input logic [1:0] bg, input logic [1:0] b,
                         input logic [14:0] row, input logic [10:0] col, input int stop,
                         output int o_acc, output int o_cas);
    int idx, cls, nxt, t, t_pre, t_act, t_cas;
    logic [33:0] e;
    for (int i = 0; i < 8; i++) obs_t[i] = -1;
    obs_pol = 2'd0;
    req_valid = 1'b1; req_rd_wr = rw; req_bank_group = bg; req_bank = b;
    req_row = row; req_column = col;
    checks++;
    assert (req_ready === 1'b1) else begin
      failures++;
      $error("FAIL ready_before_accept observed=%b expected=1", req_ready);
    end
    tick();
    o_acc = cyc;
    req_valid = 1'b0;
    req_rd_wr = 1'($urandom); req_bank_group = 2'($urandom); req_bank = 2'($urandom);
    req_row = 15'($urandom); req_column = 11'($urandom);

    idx = int'({bg, b});
    cls = !m_open[idx] ? 3 : ((m_row[idx] == int'(row)) ? 1 : 2);
    nxt = o_acc + 2; t_pre = -1; t_act = -1;
    if (cls == 2) begin
      t = nxt;
      while (!((t - m_act[idx] >= 52) && (t - m_wr[idx] >= 44))) t++;
      t_pre = t; m_pre[idx] = t; m_open[idx] = 0; nxt = t + 1;
    end
    if (cls != 1) begin
      t = nxt;
      while (!((t - m_pre[idx] >= 24) &&
               (t - m_gact >= ((int'(bg) == m_gact_bg) ? 6 : 4)))) t++;
      t_act = t; m_act[idx] = t; m_open[idx] = 1; m_row[idx] = int'(row);
      m_gact = t; m_gact_bg = int'(bg); nxt = t + 1;
    end
    t = nxt;
    while (!((t - m_act[idx] >= 24) &&
             (t - m_gcas >= ((int'(bg) == m_gcas_bg) ? 8 : 4)) &&
             (n_pend_from(t) < 8) &&
             ((rw == m_gcas_rw) || (n_pend_from(t) == 0)))) t++;
    t_cas = t; m_gcas = t; m_gcas_bg = int'(bg); m_gcas_rw = rw;
    if (rw) m_wr[idx] = t;
    pend.push_back('{d: t + (rw ? 24 : 28), rw: rw});
    o_cas = t_cas;

    check_cycle('0, 1'b0, 2'd0);
    while (cyc < t_cas && cyc < o_acc + stop) begin
      tick();
      if (cyc == t_pre)      e = mk_cmd(3'd2, bg, b, 15'd0, 11'd0);
      else if (cyc == t_act) e = mk_cmd(3'd1, bg, b, row, 11'd0);
      else if (cyc == t_cas) e = mk_cmd(rw ? 3'd4 : 3'd3, bg, b, 15'd0, col);
      else                   e = '0;
      check_cycle(e, cyc == t_cas, 2'(cls));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cas, a1, c1, c2, a_act1, p, act2;
    logic [33:0] zero_cmd;
    rst_n = 1'b0; req_valid = 1'b0; req_rd_wr = 1'b0; req_bank_group = '0;
    req_bank = '0; req_row = '0; req_column = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    zero_cmd = '0;
    checks++;
    assert ({req_ready, cmd_valid, cmd_op, cmd_bank_group, cmd_bank, cmd_row, cmd_column,
             cmd_policy, done, done_rd_wr} === {1'b1, zero_cmd, 2'b00, 2'b00}) else begin
      failures++;
      $error("FAIL reset_outputs observed ready=%b cmd_valid=%b policy=%0d done=%b expected ready=1 rest 0",
             req_ready, cmd_valid, cmd_policy, done);
    end
    rst_n = 1'b1;
    idle(2);

    // EMPTY read from reset, then HIT read right after its RD.
    obs_done_q.delete();
    run_req(1'b0, 2'd0, 2'd0, 15'd5, 11'd3, 1000, a1, c1);
    chk_int("empty_act_latency", obs_t[1] - a1, 2);
    chk_int("empty_rd_latency", obs_t[3] - a1, 26);
    chk_int("empty_policy", int'(obs_pol), 3);
    c1 = obs_t[3];
    run_req(1'b0, 2'd0, 2'd0, 15'd5, 11'd4, 1000, acc, c2);
    chk_int("hit_rd_ccd_l", obs_t[3] - c1, 8);
    chk_int("hit_policy", int'(obs_pol), 1);
    c2 = obs_t[3];
    idle(40);
    chk_int("done1_time", (obs_done_q.size() > 0) ? obs_done_q[0] - a1 : -1, 54);
    chk_int("done2_time", (obs_done_q.size() > 1) ? obs_done_q[1] - c2 : -1, 28);

    // MISS right after an ACT: tRAS, tRP, tRCD chain.
    run_req(1'b0, 2'd1, 2'd2, 15'd3, 11'd0, 1000, acc, cas);
    a_act1 = obs_t[1];
    run_req(1'b0, 2'd1, 2'd2, 15'd9, 11'd1, 1000, acc, cas);
    chk_int("miss_policy", int'(obs_pol), 2);
    chk_int("miss_pre_tras", obs_t[2] - a_act1, 52);
    chk_int("miss_act_trp", obs_t[1] - obs_t[2], 24);
    chk_int("miss_rd_trcd", obs_t[3] - obs_t[1], 24);
    idle(30);

    // Consecutive EMPTY reads, different and same bank group.
    run_req(1'b0, 2'd3, 2'd0, 15'd1, 11'd0, 1000, acc, cas);
    a_act1 = obs_t[1];
    run_req(1'b0, 2'd2, 2'd0, 15'd1, 11'd0, 1000, acc, cas);
    chk_ge("act_act_diff_bg", obs_t[1] - a_act1, 4);
    run_req(1'b0, 2'd3, 2'd2, 15'd1, 11'd0, 1000, acc, cas);
    a_act1 = obs_t[1];
    run_req(1'b0, 2'd3, 2'd3, 15'd1, 11'd0, 1000, acc, cas);
    chk_ge("act_act_same_bg", obs_t[1] - a_act1, 6);
    idle(30);

    // Write, read-after-write turnaround, then MISS gated by write recovery.
    run_req(1'b1, 2'd2, 2'd3, 15'd1, 11'd8, 1000, acc, cas);
    c1 = obs_t[4];
    a_act1 = obs_t[1];
    run_req(1'b0, 2'd2, 2'd3, 15'd1, 11'd9, 1000, acc, cas);
    chk_int("rd_after_wr_drain", obs_t[3] - c1, 25);
    run_req(1'b0, 2'd2, 2'd3, 15'd2, 11'd9, 1000, acc, cas);
    p = obs_t[2];
    act2 = obs_t[1];
    chk_int("pre_after_wr", p - c1, 44);
    chk_ge("pre_after_act", p - a_act1, 52);
    chk_int("act_after_pre", act2 - p, 24);
    idle(30);

    // Reset while waiting to precharge, with a read burst still pending.
    run_req(1'b0, 2'd1, 2'd1, 15'd4, 11'd0, 1000, acc, cas);
    run_req(1'b0, 2'd1, 2'd1, 15'd6, 11'd0, 5, acc, cas);
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({req_ready, cmd_valid, cmd_op, cmd_policy, done, done_rd_wr} === 9'b1_0_000_00_0_0) else begin
      failures++;
      $error("FAIL async_reset observed=%b expected=%b",
             {req_ready, cmd_valid, cmd_op, cmd_policy, done, done_rd_wr}, 9'b1_0_000_00_0_0);
    end
    model_reset();
    tick(); check_cycle('0, 1'b1, 2'd0);
    tick(); check_cycle('0, 1'b1, 2'd0);
    rst_n = 1'b1;
    obs_done_q.delete();
    idle(40);
    chk_int("no_stale_done", obs_done_q.size(), 0);
    run_req(1'b0, 2'd1, 2'd1, 15'd6, 11'd2, 1000, acc, cas);
    chk_int("post_reset_empty", int'(obs_pol), 3);
    idle(30);

    // Randomized request stream over a small bank/row set.
    for (int n = 0; n < 60; n++) begin
      run_req(1'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 1)),
              15'($urandom_range(0, 2)), 11'($urandom), 1000, acc, cas);
      idle($urandom_range(0, 2));
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
